// File: rtl/prefetch_queue_if.sv
// Purpose: bundles the program-ROM read port and the decoder-facing byte
//          stream of the 8051 prefetch stage.
// Signals:
//   rom_rd / rom_addr  : ROM read strobe and address (prefetcher -> ROM)
//   rom_data           : ROM byte, returned one cycle after rom_rd
//   op_valid/op_byte/op_pc : queue head presented to the decoder
//   op_ready           : decoder accepts the head
//   jmp / jmp_addr     : flush and restart fetching at jmp_addr
// Modports: master = prefetcher side, slave = ROM/decoder/core side.
interface prefetch_queue_if #(
  parameter int ADDR_W = 16
);
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              op_valid;
  logic [7:0]        op_byte;
  logic [ADDR_W-1:0] op_pc;
  logic              op_ready;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_addr;

  modport master (
    output rom_rd, rom_addr, op_valid, op_byte, op_pc,
    input  rom_data, op_ready, jmp, jmp_addr
  );

  modport slave (
    input  rom_rd, rom_addr, op_valid, op_byte, op_pc,
    output rom_data, op_ready, jmp, jmp_addr
  );
endinterface

// File: rtl/prefetch_queue.sv
// Purpose: instruction prefetch stage. Issues reads to the synchronous
//          program ROM ahead of execution, buffers returned bytes with their
//          addresses in a DEPTH-entry FIFO and presents the head to the
//          decoder. A jump flushes the queue and any in-flight read and
//          restarts fetching at the jump target.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : prefetch_queue_if.master (ROM port, decoder stream, jump request)
module prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  prefetch_queue_if.master      bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_pc_p1;
  logic [7:0]        r_mem_byte [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [7:0]        r_last_byte;
  logic [ADDR_W-1:0] r_last_pc;

  logic [CNT_W-1:0]  w_occ;
  logic              w_empty;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  // Occupancy counts the read in flight so a returning byte always has a slot.
  assign w_occ   = r_count + CNT_W'(r_vld_p1);
  assign w_empty = (r_count == '0);
  assign w_issue = ~rst & ~bus.jmp & (w_occ < CNT_W'(DEPTH));
  // A jump in the return cycle cancels the returning byte and any pop.
  assign w_push  = r_vld_p1 & ~bus.jmp;
  assign w_pop   = ~w_empty & bus.op_ready & ~bus.jmp;

  assign bus.rom_rd   = w_issue;
  assign bus.rom_addr = r_fetch_pc;
  assign bus.op_valid = ~w_empty;
  // While empty the outputs hold whatever head was last on display.
  assign bus.op_byte  = w_empty ? r_last_byte : r_mem_byte[r_rd_ptr];
  assign bus.op_pc    = w_empty ? r_last_pc   : r_mem_pc[r_rd_ptr];

  // Stage p0 -> p1: issue read, remember that a byte returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= '0;
      r_vld_p1    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_byte <= '0;
      r_last_pc   <= '0;
    end else begin
      if (!w_empty) begin
        r_last_byte <= r_mem_byte[r_rd_ptr];
        r_last_pc   <= r_mem_pc[r_rd_ptr];
      end
      if (bus.jmp) begin
        r_fetch_pc <= bus.jmp_addr;
        r_vld_p1   <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        r_vld_p1 <= w_issue;
        if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        if (w_push)  r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        if (w_pop)   r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Stage p1 -> queue: capture returned byte with the address it was read from.
  always_ff @(posedge clk) begin
    if (w_issue) r_pc_p1 <= r_fetch_pc;
    if (w_push) begin
      r_mem_byte[r_wr_ptr] <= bus.rom_data;
      r_mem_pc[r_wr_ptr]   <= r_pc_p1;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefetch_queue_if #(.ADDR_W(16)) bus ();

  prefetch_queue #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h02;
      16'h0001: return 8'h00;
      16'h0002: return 8'h10;
      16'h0003: return 8'hE4;
      16'h0100: return 8'h75;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Synchronous program ROM: data one cycle after the read strobe.
  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom_f(bus.rom_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of (byte, pc) entries plus one pending read.
  typedef struct { logic [7:0] b; logic [15:0] pc; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_fpc;
  logic        m_pend;
  logic [15:0] m_pend_pc;
  logic [7:0]  m_last_b;
  logic [15:0] m_last_pc;
  logic        m_rd_now;

  function automatic logic m_rd();
    return !rst && !bus.jmp && ((mq.size() + (m_pend ? 1 : 0)) < 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_fpc = 16'h0; m_pend = 1'b0; m_pend_pc = 16'h0;
      m_last_b = 8'h0; m_last_pc = 16'h0;
    end else begin
      m_rd_now = m_rd();
      if (mq.size() > 0) begin
        m_last_b  = mq[0].b;
        m_last_pc = mq[0].pc;
      end
      if (bus.jmp) begin
        mq.delete();
        m_pend = 1'b0;
        m_fpc  = bus.jmp_addr;
      end else begin
        if (mq.size() > 0 && bus.op_ready) void'(mq.pop_front());
        if (m_pend) mq.push_back('{rom_f(m_pend_pc), m_pend_pc});
        m_pend = m_rd_now;
        if (m_rd_now) begin
          m_pend_pc = m_fpc;
          m_fpc     = m_fpc + 16'h1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rom_rd", 32'(bus.rom_rd), 32'(m_rd()));
    if (m_rd()) chk("rom_addr", 32'(bus.rom_addr), 32'(m_fpc));
    chk("op_valid", 32'(bus.op_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("op_byte", 32'(bus.op_byte), 32'(mq[0].b));
      chk("op_pc",   32'(bus.op_pc),   32'(mq[0].pc));
    end else begin
      chk("op_byte_hold", 32'(bus.op_byte), 32'(m_last_b));
      chk("op_pc_hold",   32'(bus.op_pc),   32'(m_last_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [7:0]  exp_b [4];
  logic        r_rd  [6];
  logic [15:0] r_ad  [6];
  logic        r_v   [6];
  logic [7:0]  r_b   [6];
  logic [15:0] r_pc  [6];

  // Jump while 3 bytes are queued and one read is in flight.
  task automatic test_jmp(input logic rdy_at_jmp, input string tag);
    bus.op_ready = 1'b0;
    do_reset();
    repeat (4) step();
    chk({tag, "_pre_valid"}, 32'(bus.op_valid), 32'd1);
    bus.jmp = 1'b1; bus.jmp_addr = 16'h0100; bus.op_ready = rdy_at_jmp;
    #1;
    chk({tag, "_rd_in_jmp"}, 32'(bus.rom_rd), 32'd0);
    step();
    bus.jmp = 1'b0; bus.op_ready = 1'b0;
    #1;
    chk({tag, "_v1"}, 32'(bus.op_valid), 32'd0);
    chk({tag, "_rd1"}, 32'(bus.rom_rd), 32'd1);
    chk({tag, "_addr1"}, 32'(bus.rom_addr), 32'h0100);
    step(); #1;
    chk({tag, "_v2"}, 32'(bus.op_valid), 32'd0);
    step(); #1;
    chk({tag, "_v3"}, 32'(bus.op_valid), 32'd1);
    chk({tag, "_byte3"}, 32'(bus.op_byte), 32'h75);
    chk({tag, "_pc3"}, 32'(bus.op_pc), 32'h0100);
    bus.op_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    int n;
    int got;
    logic seen;
    logic [15:0] first_addr;
    logic [7:0]  gb [4];
    logic [15:0] gp [4];

    exp_b[0] = 8'h02; exp_b[1] = 8'h00; exp_b[2] = 8'h10; exp_b[3] = 8'hE4;
    rst = 1'b1; bus.op_ready = 1'b0; bus.jmp = 1'b0; bus.jmp_addr = 16'h0;
    step(); step();
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_rom_rd",   32'(bus.rom_rd),   32'd0);
    chk("rst_op_byte",  32'(bus.op_byte),  32'h00);
    chk("rst_op_pc",    32'(bus.op_pc),    32'h0000);

    // Test 1: streaming from reset with the decoder always ready.
    bus.op_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      r_rd[i] = bus.rom_rd; r_ad[i] = bus.rom_addr;
      r_v[i] = bus.op_valid; r_b[i] = bus.op_byte; r_pc[i] = bus.op_pc;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd", 32'(r_rd[i]), 32'd1);
      chk("t1_addr", 32'(r_ad[i]), 32'(i));
    end
    chk("t1_v0", 32'(r_v[0]), 32'd0);
    chk("t1_v1", 32'(r_v[1]), 32'd0);
    for (int i = 2; i < 6; i++) begin
      chk("t1_valid", 32'(r_v[i]), 32'd1);
      chk("t1_byte", 32'(r_b[i]), 32'(exp_b[i-2]));
      chk("t1_pc", 32'(r_pc[i]), 32'(i-2));
    end

    // Test 2: decoder stalled from reset; queue fills, then drains in order.
    bus.op_ready = 1'b0;
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.rom_rd) n++;
      step();
    end
    chk("t2_reads", 32'(n), 32'd4);
    #1;
    chk("t2_rd_stays0", 32'(bus.rom_rd), 32'd0);
    bus.op_ready = 1'b1;
    got = 0; seen = 1'b0; first_addr = 16'hDEAD;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.op_valid && got < 4) begin
        gb[got] = bus.op_byte; gp[got] = bus.op_pc; got++;
      end
      if (bus.rom_rd && !seen) begin
        seen = 1'b1; first_addr = bus.rom_addr;
      end
      step();
    end
    chk("t2_got", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got) begin
        chk("t2_byte", 32'(gb[i]), 32'(exp_b[i]));
        chk("t2_pc", 32'(gp[i]), 32'(i));
      end
    end
    chk("t2_resume_addr", 32'(first_addr), 32'h0004);

    // Tests 3 and 4: flush with and without a coincident pop.
    test_jmp(1'b0, "t3");
    test_jmp(1'b1, "t4");

    // Test 5: address wrap through 0xFFFF.
    bus.op_ready = 1'b1;
    bus.jmp = 1'b1; bus.jmp_addr = 16'hFFFE;
    step();
    bus.jmp = 1'b0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.op_valid && got < 4) begin
        gp[got] = bus.op_pc; got++;
      end
      step();
    end
    chk("t5_got", 32'(got), 32'd4);
    if (got == 4) begin
      chk("t5_pc0", 32'(gp[0]), 32'hFFFE);
      chk("t5_pc1", 32'(gp[1]), 32'hFFFF);
      chk("t5_pc2", 32'(gp[2]), 32'h0000);
      chk("t5_pc3", 32'(gp[3]), 32'h0001);
    end

    // Test 6: asynchronous reset mid-stream.
    bus.jmp = 1'b1; bus.jmp_addr = 16'h0040;
    step();
    bus.jmp = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.rom_rd && bus.rom_addr == 16'h0042) seen = 1'b1;
      else step();
    end
    chk("t6_reached_0042", 32'(seen), 32'd1);
    chk("t6_valid_before", 32'(bus.op_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_valid_in_rst", 32'(bus.op_valid), 32'd0);
    chk("t6_rd_in_rst", 32'(bus.rom_rd), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_rd_after", 32'(bus.rom_rd), 32'd1);
    chk("t6_addr_after", 32'(bus.rom_addr), 32'h0000);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
